// File: rtl/pmips_mem_pkg.sv
// Shared types for the PMIPSL0 unified memory port.
// State encoding, grant IDs and the default wait-state count.
package pmips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_RD   = 2'd2,
    D_WR   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  localparam int unsigned WAIT_STATES_DEF = 1;
  localparam int unsigned CNT_W           = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// The arbiter is the slave; requesters and memory form the master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              stall_if;
  logic              stall_d;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output stall_if, stall_d,
    output mem_addr, mem_wdata,
    output mem_re, mem_we
  );

  modport master (
    output if_req, if_addr,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  stall_if, stall_d,
    input  mem_addr, mem_wdata,
    input  mem_re, mem_we
  );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter timing the wait states of one access.
// Holds at zero; load has priority over enable.
module mem_wait_counter
  import pmips_mem_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// Holds each grant for WAIT_STATES+1 cycles, then pulses ready.
module mem_port_arbiter
  import pmips_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d;
  logic              if_rdy_q, if_rdy_d;
  logic              d_rdy_q, d_rdy_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;

  logic if_pend, d_pend;
  logic gnt_if, gnt_d;
  logic busy, cnt_zero, done;

  // A requester in its ready cycle is still holding the old request.
  assign if_pend = bus.if_req & ~if_rdy_q;
  assign d_pend  = (bus.d_read | bus.d_write) & ~d_rdy_q;

  assign gnt_d  = (state_q == IDLE) & d_pend
                & (~if_pend | (last_q == GRANT_IF));
  assign gnt_if = (state_q == IDLE) & if_pend & ~gnt_d;

  assign busy = (state_q != IDLE);
  assign done = busy & cnt_zero;

  mem_wait_counter u_wait (
    .clk_i  (clock),
    .rst_ni (reset),
    .load_i (gnt_d | gnt_if),
    .en_i   (busy),
    .val_i  (CNT_W'(WAIT_STATES)),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d = bus.d_write ? D_WR : D_RD;
        end else if (gnt_if) begin
          state_d = IF_ACC;
        end
      end
      IF_ACC, D_RD, D_WR: begin
        if (cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d     = last_q;
    if_rdy_d   = 1'b0;
    d_rdy_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    re_d       = (state_d == IF_ACC) | (state_d == D_RD);
    we_d       = (state_d == D_WR);
    unique case (1'b1)
      gnt_d: begin
        last_d  = GRANT_D;
        addr_d  = bus.d_addr;
        wdata_d = bus.d_wdata;
      end
      gnt_if: begin
        last_d = GRANT_IF;
        addr_d = bus.if_addr;
      end
      done: begin
        if_rdy_d = (state_q == IF_ACC);
        d_rdy_d  = (state_q != IF_ACC);
        if (state_q == IF_ACC) if_rdata_d = bus.mem_rdata;
        if (state_q == D_RD) d_rdata_d = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q     <= GRANT_IF;
      if_rdy_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      last_q     <= last_d;
      if_rdy_q   <= if_rdy_d;
      d_rdy_q    <= d_rdy_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_rdy_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_rdy_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.stall_if  = bus.if_req & ~if_rdy_q;
  assign bus.stall_d   = (bus.d_read | bus.d_write) & ~d_rdy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a
// remaining-cycles reference model and a small memory.
module tb_mem_port_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .WAIT_STATES (WS),
    .ADDR_W      (16),
    .DATA_W      (16)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [15:0] env_mem [16];
  logic [15:0] ref_mem [16];

  assign bus.mem_rdata = bus.mem_re ? env_mem[bus.mem_addr[3:0]] : 16'h0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: cycles left on the port, owner and results.
  int          m_busy = 0;
  bit          m_own_d = 0;
  bit          m_wr = 0;
  bit          m_last_d = 0;
  bit          m_rdy_if = 0;
  bit          m_rdy_d = 0;
  logic [15:0] m_addr = 0;
  logic [15:0] m_wdata = 0;
  logic [15:0] m_if_rd = 0;
  logic [15:0] m_d_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit nri, nrd, wi, wd;
    nri = 0;
    nrd = 0;
    if (!rst_n) begin
      m_busy = 0; m_own_d = 0; m_wr = 0; m_last_d = 0;
      m_rdy_if = 0; m_rdy_d = 0; m_addr = 0; m_wdata = 0;
      m_if_rd = 0; m_d_rd = 0;
      return;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (!m_own_d) begin
          m_if_rd = ref_mem[m_addr[3:0]];
          nri = 1;
        end else begin
          nrd = 1;
          if (!m_wr) m_d_rd = ref_mem[m_addr[3:0]];
        end
      end
    end else begin
      wi = bus.if_req && !m_rdy_if;
      wd = (bus.d_read || bus.d_write) && !m_rdy_d;
      if (wd && (!wi || !m_last_d)) begin
        m_own_d = 1; m_last_d = 1; m_busy = WS + 1;
        m_addr = bus.d_addr; m_wdata = bus.d_wdata;
        m_wr = bus.d_write;
        if (m_wr) ref_mem[m_addr[3:0]] = m_wdata;
      end else if (wi) begin
        m_own_d = 0; m_last_d = 0; m_busy = WS + 1;
        m_addr = bus.if_addr; m_wr = 0;
      end
    end
    m_rdy_if = nri;
    m_rdy_d = nrd;
  endtask

  task automatic tick();
    #1;
    chk("stall_if", bus.stall_if, bus.if_req && !m_rdy_if);
    chk("stall_d", bus.stall_d,
        (bus.d_read || bus.d_write) && !m_rdy_d);
    if (bus.mem_we) env_mem[bus.mem_addr[3:0]] = bus.mem_wdata;
    model_step();
    @(posedge clk);
    #1;
    chk("mem_re", bus.mem_re, m_busy > 0 && !m_wr);
    chk("mem_we", bus.mem_we, m_busy > 0 && m_wr);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ready", bus.if_ready, m_rdy_if);
    chk("d_ready", bus.d_ready, m_rdy_d);
    chk("if_rdata", bus.if_rdata, m_if_rd);
    chk("d_rdata", bus.d_rdata, m_d_rd);
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    int seq[$];
    bit if_act, d_act;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 16'($urandom);
      ref_mem[i] = env_mem[i];
    end
    idle_inputs();
    do_reset();
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);

    // Fetch only
    env_mem[0] = 16'h1234;
    ref_mem[0] = 16'h1234;
    bus.if_req = 1; bus.if_addr = 16'h0010;
    tick();
    chk("f_re_c1", bus.mem_re, 1);
    chk("f_addr_c1", bus.mem_addr, 16'h0010);
    tick();
    chk("f_re_c2", bus.mem_re, 1);
    tick();
    chk("f_ready_c3", bus.if_ready, 1);
    chk("f_rdata_c3", bus.if_rdata, 16'h1234);
    chk("f_re_c3", bus.mem_re, 0);
    bus.if_req = 0;
    tick();
    chk("f_ready_c4", bus.if_ready, 0);

    // Store
    bus.d_write = 1; bus.d_addr = 16'h0040; bus.d_wdata = 16'hBEEF;
    tick();
    chk("s_we_c1", bus.mem_we, 1);
    chk("s_re_c1", bus.mem_re, 0);
    chk("s_addr_c1", bus.mem_addr, 16'h0040);
    chk("s_wdata_c1", bus.mem_wdata, 16'hBEEF);
    tick();
    chk("s_we_c2", bus.mem_we, 1);
    tick();
    chk("s_ready_c3", bus.d_ready, 1);
    chk("s_we_c3", bus.mem_we, 0);
    bus.d_write = 0;
    tick();

    // Masking: fetch request held through its ready cycle
    bus.if_req = 1; bus.if_addr = 16'h0003;
    tick(); tick(); tick();
    chk("m_ready", bus.if_ready, 1);
    tick();
    chk("m_no_regrant", bus.mem_re, 0);
    tick();
    chk("m_regrant", bus.mem_re, 1);
    tick(); tick();
    chk("m_ready2", bus.if_ready, 1);
    bus.if_req = 0;
    tick();

    // Contention: order D, IF, D, IF
    do_reset();
    bus.if_req = 1; bus.if_addr = 16'h0020;
    bus.d_read = 1; bus.d_addr = 16'h0031;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.d_ready) seq.push_back(1);
      if (bus.if_ready) seq.push_back(0);
    end
    chk("c_count", seq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk("c_order", seq[i], (i % 2 == 0) ? 1 : 0);
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();

    // Reset in the second cycle of a data read
    bus.d_read = 1; bus.d_addr = 16'h0005;
    tick();
    tick();
    chk("r_re_c2", bus.mem_re, 1);
    rst_n = 0;
    bus.d_read = 0;
    tick();
    chk("r_re", bus.mem_re, 0);
    chk("r_ready", bus.d_ready, 0);
    chk("r_rdata", bus.d_rdata, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r_no_ready", bus.d_ready, 0);
    end

    // Both data enables: the write wins
    bus.d_read = 1; bus.d_write = 1;
    bus.d_addr = 16'h0007; bus.d_wdata = 16'h5A5A;
    tick();
    chk("b_we", bus.mem_we, 1);
    chk("b_re", bus.mem_re, 0);
    tick(); tick();
    chk("b_ready", bus.d_ready, 1);
    idle_inputs();
    tick();

    // Random traffic
    if_act = 0;
    d_act = 0;
    for (int c = 0; c < 800; c++) begin
      if (bus.if_ready) begin
        if_act = 1'($urandom_range(0, 1));
        bus.if_addr = 16'($urandom);
      end else if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1;
        bus.if_addr = 16'($urandom);
      end
      if (bus.d_ready || (!d_act && $urandom_range(0, 2) == 0)) begin
        d_act = bus.d_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        case ($urandom_range(0, 6))
          0, 1, 2: begin bus.d_read = 1; bus.d_write = 0; end
          3, 4, 5: begin bus.d_read = 0; bus.d_write = 1; end
          default: begin bus.d_read = 1; bus.d_write = 1; end
        endcase
        bus.d_addr = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
      if (!d_act) begin
        bus.d_read = 0;
        bus.d_write = 0;
      end
      bus.if_req = if_act;
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
